// File: rtl/ro_freq_counter_if.sv
// Result handshake bundle between ro_freq_counter and its consumer.
//   start  : consumer -> counter, one-cycle measurement request
//   ready  : consumer -> counter, result accepted
//   busy   : counter -> consumer, measurement in progress (not IDLE)
//   valid  : counter -> consumer, count/ovf available
//   count  : counter -> consumer, rising-edge count (CNT_W bits)
//   ovf    : counter -> consumer, count exceeded its range during the window
// Modports: master = consumer side, slave = ro_freq_counter side.
interface ro_freq_counter_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (
        output start,
        output ready,
        input  busy,
        input  valid,
        input  count,
        input  ovf
    );

    modport slave (
        input  start,
        input  ready,
        output busy,
        output valid,
        output count,
        output ovf
    );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter. Enables one gated ring, lets it settle,
// counts synchronised rising edges of ro_in over a fixed gate window, then
// presents the count over a valid/ready handshake.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   ro_in      : ring output, asynchronous to clk, idles high when disabled
//   ro_enable  : registered ring enable, high in SETTLE and GATE
//   bus        : ro_freq_counter_if.slave (start, ready, busy, valid, count, ovf)
// Build option: define ROFC_SAT_EN to saturate count at its maximum on
// overflow; otherwise count wraps. ovf is sticky until the next start.
module ro_freq_counter #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned GATE_CYCLES   = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ro_in,
    output logic                   ro_enable,
    ro_freq_counter_if.slave       bus
);

    localparam int unsigned MAX_LOAD = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int unsigned TMR_W    = (MAX_LOAD > 2) ? $clog2(MAX_LOAD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;
    logic               valid_q;
    logic               busy_q;
    logic               s1_q, s2_q, s3_q;
    logic               rise;

    // Two-flop synchroniser plus history flop; reset high to match idle ring.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= ro_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Measurement sequencer; the shared timer counts SETTLE, GATE and DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ro_enable <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= SETTLE;
                        tmr_q     <= TMR_W'(SETTLE_CYCLES - 1);
                        count_q   <= '0;
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        ro_enable <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (tmr_q == '0) begin
                        state_q <= GATE;
                        tmr_q   <= TMR_W'(GATE_CYCLES - 1);
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                GATE: begin
                    if (rise) begin
                        if (count_q == {CNT_W{1'b1}}) begin
                            ovf_q <= 1'b1;
`ifdef ROFC_SAT_EN
                            count_q <= count_q;
`else
                            count_q <= '0;
`endif
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    if (tmr_q == '0) begin
                        state_q   <= DRAIN;
                        tmr_q     <= TMR_W'(1);
                        ro_enable <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                DRAIN: begin
                    // Two cycles so edges still in the synchroniser are dropped.
                    if (tmr_q == '0) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                DONE: begin
                    if (valid_q && bus.ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    valid_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    ro_enable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: two instances (S=4/G=16/16-bit and
// S=4/G=40/4-bit) share one generated ro_in. A vector table covers the
// nominal, stuck, fast and overflow cases; hand sequences cover backpressure,
// reset mid-gate and back-to-back starts. Edge E_k is checked at the negedge
// just before it, so "high at E_k" is observed directly.
module tb_ro_freq_counter;

    localparam int unsigned S_CYC = 4;
    localparam int unsigned G0    = 16;
    localparam int unsigned G1    = 40;

`ifdef ROFC_SAT_EN
    localparam logic [15:0] OVF_CNT = 16'd15;
`else
    localparam logic [15:0] OVF_CNT = 16'd4;
`endif

    logic clk;
    logic rst;
    logic ro_in;
    logic en0, en1;

    ro_freq_counter_if #(.CNT_W(16)) b0 ();
    ro_freq_counter_if #(.CNT_W(4))  b1 ();

    ro_freq_counter #(.SETTLE_CYCLES(S_CYC), .GATE_CYCLES(G0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .ro_in(ro_in), .ro_enable(en0), .bus(b0)
    );

    ro_freq_counter #(.SETTLE_CYCLES(S_CYC), .GATE_CYCLES(G1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .ro_in(ro_in), .ro_enable(en1), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring model: 0 = stuck high, 1 = toggle every 2 clk cycles, 2 = every cycle.
    int mode;
    int phase;
    initial begin
        ro_in = 1'b1;
        phase = 0;
    end
    always @(negedge clk) begin
        phase = phase + 1;
        case (mode)
            1:       if (phase % 2 == 1) ro_in = ~ro_in;
            2:       ro_in = ~ro_in;
            default: ro_in = 1'b1;
        endcase
    end

    // Observation mux for the selected instance.
    int          sel;
    logic        en_s, busy_s, valid_s, ovf_s;
    logic [15:0] cnt_s;
    always_comb begin
        if (sel == 0) begin
            en_s    = en0;
            busy_s  = b0.busy;
            valid_s = b0.valid;
            ovf_s   = b0.ovf;
            cnt_s   = b0.count;
        end else begin
            en_s    = en1;
            busy_s  = b1.busy;
            valid_s = b1.valid;
            ovf_s   = b1.ovf;
            cnt_s   = 16'(b1.count);
        end
    end

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) b0.start = v; else b1.start = v;
    endtask

    task automatic set_ready(input logic v);
        if (sel == 0) b0.ready = v; else b1.ready = v;
    endtask

    // Called at a negedge with the selected instance idle; start is sampled
    // at the following posedge (E0).
    task automatic measure(input int d, input int g, input logic [15:0] exp_cnt,
                           input logic exp_ovf, input bit ack, input string tag);
        int en_cycles, en_first, en_last, valid_k;
        sel = d;
        #0;
        check({tag, "_idle_before"}, 32'(busy_s), 32'd0);
        set_start(1'b1);
        en_cycles = 0;
        en_first  = 0;
        en_last   = 0;
        valid_k   = 0;
        for (int k = 1; k <= S_CYC + g + 10; k++) begin
            @(negedge clk);
            if (k == 1) set_start(1'b0);
            if (en_s) begin
                en_cycles++;
                if (en_first == 0) en_first = k;
                en_last = k;
            end
            if (valid_s) begin
                valid_k = k;
                break;
            end
        end
        check({tag, "_valid_edge"}, 32'(valid_k), 32'(S_CYC + g + 3));
        check({tag, "_en_cycles"},  32'(en_cycles), 32'(S_CYC + g));
        check({tag, "_en_first"},   32'(en_first), 32'd1);
        check({tag, "_en_last"},    32'(en_last), 32'(S_CYC + g));
        check({tag, "_count"},      32'(cnt_s), 32'(exp_cnt));
        check({tag, "_ovf"},        32'(ovf_s), 32'(exp_ovf));
        check({tag, "_busy_done"},  32'(busy_s), 32'd1);
        if (ack) begin
            set_ready(1'b1);
            @(negedge clk);
            set_ready(1'b0);
            check({tag, "_valid_after_ack"}, 32'(valid_s), 32'd0);
            check({tag, "_busy_after_ack"},  32'(busy_s), 32'd0);
            check({tag, "_count_held"},      32'(cnt_s), 32'(exp_cnt));
            check({tag, "_ovf_held"},        32'(ovf_s), 32'(exp_ovf));
        end
    endtask

    typedef struct {
        int          dut;
        int          g;
        int          ro_mode;
        logic [15:0] exp_cnt;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, G0, 1, 16'd4,  1'b0, "nominal"};
        vecs[1] = '{0, G0, 0, 16'd0,  1'b0, "stuck"};
        vecs[2] = '{0, G0, 2, 16'd8,  1'b0, "fast"};
        vecs[3] = '{1, G1, 1, 16'd10, 1'b0, "g40_nominal"};
        vecs[4] = '{1, G1, 2, OVF_CNT, 1'b1, "overflow"};
        vecs[5] = '{1, G1, 0, 16'd0,  1'b0, "ovf_cleared"};

        n_checks = 0;
        n_errors = 0;
        mode     = 0;
        sel      = 0;
        rst      = 1'b1;
        b0.start = 1'b0;
        b0.ready = 1'b0;
        b1.start = 1'b0;
        b1.ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_en0",    32'(en0), 32'd0);
        check("rst_busy0",  32'(b0.busy), 32'd0);
        check("rst_valid0", 32'(b0.valid), 32'd0);
        check("rst_count0", 32'(b0.count), 32'd0);
        check("rst_ovf0",   32'(b0.ovf), 32'd0);
        check("rst_en1",    32'(en1), 32'd0);
        check("rst_valid1", 32'(b1.valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].ro_mode;
            repeat (4) @(negedge clk);
            measure(vecs[i].dut, vecs[i].g, vecs[i].exp_cnt, vecs[i].exp_ovf, 1'b1, vecs[i].name);
        end

        // Backpressure: result held, start pulses ignored while waiting.
        mode = 1;
        repeat (4) @(negedge clk);
        measure(0, G0, 16'd4, 1'b0, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            set_start((i % 2) == 0);
            @(negedge clk);
            check("bp_count_stable", 32'(cnt_s), 32'd4);
            check("bp_busy",         32'(busy_s), 32'd1);
            check("bp_valid",        32'(valid_s), 32'd1);
        end
        set_start(1'b0);
        set_ready(1'b1);
        @(negedge clk);
        set_ready(1'b0);
        check("bp_busy_release",  32'(busy_s), 32'd0);
        check("bp_valid_release", 32'(valid_s), 32'd0);
        check("bp_count_idle",    32'(cnt_s), 32'd4);
        repeat (3) @(negedge clk);
        check("bp_no_queued_start", 32'(busy_s), 32'd0);
        check("bp_no_queued_en",    32'(en_s), 32'd0);

        // Reset in the middle of GATE, then a fresh nominal measurement.
        sel = 0;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (9) @(negedge clk);
        check("midgate_en",   32'(en_s), 32'd1);
        check("midgate_busy", 32'(busy_s), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_en",    32'(en_s), 32'd0);
        check("rst_mid_busy",  32'(busy_s), 32'd0);
        check("rst_mid_count", 32'(cnt_s), 32'd0);
        check("rst_mid_valid", 32'(valid_s), 32'd0);
        repeat (4) @(negedge clk);
        measure(0, G0, 16'd4, 1'b0, 1'b1, "after_rst");

        // Back-to-back: second start in the cycle right after the handshake.
        measure(0, G0, 16'd4, 1'b0, 1'b1, "b2b_first");
        measure(0, G0, 16'd4, 1'b0, 1'b1, "b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
